// File: rtl/ffe_sample_feeder.sv
// ffe_sample_feeder: write/sequencing side of the FFE tap interface.
// Accepts samples over x_valid/x_ready and keeps the last DEPTH of them in a
// circular delay line. Each accepted sample is replayed newest-first, one tap
// per cycle, to ffe_datapath. The last tap raises str_out_n_rst_add_reg.
// Optional feature macro: FFE_BACK_TO_BACK_EN accepts the next sample on the
// last-tap cycle, so back-to-back sequences need no idle cycle between them.
module ffe_sample_feeder #(
    parameter int unsigned IN_OUT_BUS_WIDTH = 12,
    parameter int unsigned DEPTH            = 4,
    parameter int unsigned ADDR_SIZE        = $clog2(DEPTH)
) (
    input  logic                        ffe_clk,
    input  logic                        rst,
    input  logic [IN_OUT_BUS_WIDTH-1:0] x_in,
    input  logic                        x_valid,
    output logic                        x_ready,
    input  logic                        clr_hist,
    output logic [ADDR_SIZE-1:0]        rd_addr,
    output logic [IN_OUT_BUS_WIDTH-1:0] rd_data,
    output logic                        str_out_n_rst_add_reg,
    output logic                        out_valid
);

    localparam int unsigned           PTR_W    = ADDR_SIZE + 1;
    localparam logic [ADDR_SIZE-1:0]  LAST_IDX = ADDR_SIZE'(DEPTH - 1);
    localparam logic [PTR_W-1:0]      DEPTH_P  = PTR_W'(DEPTH);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t                      state_q;
    state_t                      state_d;
    logic [ADDR_SIZE-1:0]        tap_q;
    logic [ADDR_SIZE-1:0]        tap_d;
    logic [ADDR_SIZE-1:0]        wr_ptr_q;
    logic [ADDR_SIZE-1:0]        wr_ptr_d;
    logic [ADDR_SIZE-1:0]        newest_q;
    logic [ADDR_SIZE-1:0]        newest_d;
    logic [IN_OUT_BUS_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_SIZE-1:0]        tap_nxt;
    logic [PTR_W-1:0]            rd_sum;
    logic [ADDR_SIZE-1:0]        rd_idx;

    logic                        ready_c;
    logic                        accept;
    logic                        clear;
    logic [ADDR_SIZE-1:0]        rd_addr_d;
    logic [IN_OUT_BUS_WIDTH-1:0] rd_data_d;
    logic                        strobe_d;

    // Delay-line index of the next tap: (newest - tap) mod DEPTH via add of DEPTH
    always_comb begin
        tap_nxt = tap_q + ADDR_SIZE'(1);
        rd_sum  = PTR_W'(newest_q) + DEPTH_P - PTR_W'(tap_nxt);
        if (rd_sum >= DEPTH_P) begin
            rd_sum = rd_sum - DEPTH_P;
        end
        rd_idx = ADDR_SIZE'(rd_sum);
    end

    // Next-state and next-output logic; outputs are computed one cycle ahead
    always_comb begin
        state_d   = state_q;
        tap_d     = tap_q;
        wr_ptr_d  = wr_ptr_q;
        newest_d  = newest_q;
        ready_c   = 1'b0;
        clear     = 1'b0;
        rd_addr_d = '0;
        rd_data_d = '0;
        strobe_d  = 1'b0;

        case (state_q)
            IDLE: begin
                ready_c = ~clr_hist;
                clear   = clr_hist;
                if (clr_hist) begin
                    wr_ptr_d = '0;
                end
            end
            RUN: begin
                if (tap_q == LAST_IDX) begin
                    state_d = IDLE;
`ifdef FFE_BACK_TO_BACK_EN
                    ready_c = 1'b1;
`endif
                end else begin
                    tap_d     = tap_nxt;
                    rd_addr_d = tap_nxt;
                    rd_data_d = mem_q[rd_idx];
                    strobe_d  = (tap_nxt == LAST_IDX);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // The accepted sample is tap 0 of the new sequence, forwarded directly
        // because the delay-line write lands on the same edge.
        accept = ready_c & x_valid;
        if (accept) begin
            state_d   = RUN;
            tap_d     = '0;
            newest_d  = wr_ptr_q;
            wr_ptr_d  = (wr_ptr_q == LAST_IDX) ? '0 : wr_ptr_q + ADDR_SIZE'(1);
            rd_addr_d = '0;
            rd_data_d = x_in;
            strobe_d  = 1'b0;
        end
    end

    assign x_ready   = ready_c;
    assign out_valid = str_out_n_rst_add_reg;

    // State, pointers and registered tap outputs
    always_ff @(posedge ffe_clk or negedge rst) begin
        if (!rst) begin
            state_q               <= IDLE;
            tap_q                 <= '0;
            wr_ptr_q              <= '0;
            newest_q              <= '0;
            rd_addr               <= '0;
            rd_data               <= '0;
            str_out_n_rst_add_reg <= 1'b0;
        end else begin
            state_q               <= state_d;
            tap_q                 <= tap_d;
            wr_ptr_q              <= wr_ptr_d;
            newest_q              <= newest_d;
            rd_addr               <= rd_addr_d;
            rd_data               <= rd_data_d;
            str_out_n_rst_add_reg <= strobe_d;
        end
    end

    // Delay line: clear in one cycle, otherwise write the accepted sample
    always_ff @(posedge ffe_clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (clear) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (accept) begin
            mem_q[wr_ptr_q] <= x_in;
        end
    end

endmodule

// File: tb/tb_ffe_sample_feeder.sv
// Testbench for ffe_sample_feeder: directed vector table, hand-written corner
// sequences and a randomized run against a history-queue reference model.
module tb_ffe_sample_feeder;

    localparam int W = 12;
    localparam int D = 4;
    localparam int A = 2;
`ifdef FFE_BACK_TO_BACK_EN
    localparam bit B2B = 1'b1;
`else
    localparam bit B2B = 1'b0;
`endif

    logic         ffe_clk;
    logic         rst;
    logic [W-1:0] x_in;
    logic         x_valid;
    logic         x_ready;
    logic         clr_hist;
    logic [A-1:0] rd_addr;
    logic [W-1:0] rd_data;
    logic         str_out_n_rst_add_reg;
    logic         out_valid;

    int n_pass;
    int n_total;

    ffe_sample_feeder #(
        .IN_OUT_BUS_WIDTH(W),
        .DEPTH(D),
        .ADDR_SIZE(A)
    ) dut (
        .ffe_clk(ffe_clk),
        .rst(rst),
        .x_in(x_in),
        .x_valid(x_valid),
        .x_ready(x_ready),
        .clr_hist(clr_hist),
        .rd_addr(rd_addr),
        .rd_data(rd_data),
        .str_out_n_rst_add_reg(str_out_n_rst_add_reg),
        .out_valid(out_valid)
    );

    initial ffe_clk = 1'b0;
    always #5 ffe_clk = ~ffe_clk;

    typedef struct {
        logic [W-1:0] x;
        logic         v;
        logic         c;
        logic         rdy;
        logic [A-1:0] addr;
        logic [W-1:0] data;
        logic         stb;
    } vec_t;

    typedef struct packed {
        logic [A-1:0] a;
        logic [W-1:0] d;
        logic         s;
    } ent_t;

    vec_t         vecs[16];
    logic [W-1:0] got[D];

    // reference model: newest-first history plus the queue of expected tap cycles
    logic [W-1:0] hist[D];
    ent_t         exp_q[$];
    bit           cur_idle;
    bit           cur_stb;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic vec_t mkv(input int x, input bit v, input bit c, input bit rdy,
                                 input int addr, input int data, input bit stb);
        vec_t r;
        r.x = W'(x); r.v = v; r.c = c; r.rdy = rdy;
        r.addr = A'(addr); r.data = W'(data); r.stb = stb;
        return r;
    endfunction

    task automatic do_reset();
        x_valid = 1'b0; x_in = '0; clr_hist = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge ffe_clk);
        @(negedge ffe_clk);
        rst = 1'b1;
        @(posedge ffe_clk);
        #1;
    endtask

    task automatic model_reset();
        for (int k = 0; k < D; k++) hist[k] = '0;
        exp_q.delete();
        cur_idle = 1'b1;
        cur_stb  = 1'b0;
    endtask

    // send one sample (waiting for x_ready) and capture its tap data into got[]
    task automatic send(input logic [W-1:0] x);
        int guard;
        guard = 0;
        x_in = x; x_valid = 1'b1; clr_hist = 1'b0;
        #1;
        while (!x_ready && guard < 20) begin
            @(posedge ffe_clk); #1;
            guard++;
        end
        check("send_ready", 32'(x_ready), 32'd1);
        @(posedge ffe_clk); #1;
        x_valid = 1'b0;
        for (int t = 0; t < D; t++) begin
            got[t] = rd_data;
            check("send_addr", 32'(rd_addr), 32'(t));
            check("send_stb", 32'(str_out_n_rst_add_reg), 32'(t == D - 1));
            if (t < D - 1) begin
                @(posedge ffe_clk); #1;
            end
        end
    endtask

    // one random cycle checked against the reference model
    task automatic mcycle(input logic [W-1:0] x, input logic v, input logic c);
        logic ready_e;
        ent_t e;
        bit   was_empty;
        x_in = x; x_valid = v; clr_hist = c;
        #1;
        ready_e = cur_idle ? ~c : (B2B & cur_stb);
        check("rand_ready", 32'(x_ready), 32'(ready_e));
        @(posedge ffe_clk);
        if (cur_idle && c) begin
            for (int k = 0; k < D; k++) hist[k] = '0;
        end
        if (ready_e && v) begin
            for (int k = D - 1; k > 0; k--) hist[k] = hist[k-1];
            hist[0] = x;
            for (int t = 0; t < D; t++) begin
                e.a = A'(t); e.d = hist[t]; e.s = (t == D - 1);
                exp_q.push_back(e);
            end
        end
        #1;
        was_empty = (exp_q.size() == 0);
        if (was_empty) e = '0;
        else e = exp_q.pop_front();
        cur_idle = was_empty;
        cur_stb  = e.s;
        check("rand_addr", 32'(rd_addr), 32'(e.a));
        check("rand_data", 32'(rd_data), 32'(e.d));
        check("rand_stb", 32'(str_out_n_rst_add_reg), 32'(e.s));
        check("rand_ovld", 32'(out_valid), 32'(e.s));
    endtask

    initial begin
        int nxt;
        int strobes;
        int last_t;
        logic acc;

        n_pass = 0; n_total = 0;
        x_valid = 1'b0; x_in = '0; clr_hist = 1'b0;

        // reset state
        rst = 1'b0;
        #12;
        check("rst_ready", 32'(x_ready), 32'd1);
        check("rst_addr", 32'(rd_addr), 32'd0);
        check("rst_data", 32'(rd_data), 32'd0);
        check("rst_stb", 32'(str_out_n_rst_add_reg), 32'd0);
        check("rst_ovld", 32'(out_valid), 32'd0);
        do_reset();

        // directed table: 1024, then 512 with clr_hist mid-RUN, then clr_hist in IDLE
        vecs[0]  = mkv(1024, 1, 0, 1,   0, 1024, 0);
        vecs[1]  = mkv(0,    0, 0, 0,   1, 0,    0);
        vecs[2]  = mkv(0,    0, 0, 0,   2, 0,    0);
        vecs[3]  = mkv(0,    0, 0, 0,   3, 0,    1);
        vecs[4]  = mkv(0,    0, 0, B2B, 0, 0,    0);
        vecs[5]  = mkv(512,  1, 0, 1,   0, 512,  0);
        vecs[6]  = mkv(0,    0, 1, 0,   1, 1024, 0);
        vecs[7]  = mkv(0,    0, 1, 0,   2, 0,    0);
        vecs[8]  = mkv(0,    0, 0, 0,   3, 0,    1);
        vecs[9]  = mkv(0,    0, 0, B2B, 0, 0,    0);
        vecs[10] = mkv(77,   1, 1, 0,   0, 0,    0);
        vecs[11] = mkv(77,   1, 0, 1,   0, 77,   0);
        vecs[12] = mkv(0,    0, 0, 0,   1, 0,    0);
        vecs[13] = mkv(0,    0, 0, 0,   2, 0,    0);
        vecs[14] = mkv(0,    0, 0, 0,   3, 0,    1);
        vecs[15] = mkv(0,    0, 0, B2B, 0, 0,    0);
        for (int i = 0; i < 16; i++) begin
            x_in = vecs[i].x; x_valid = vecs[i].v; clr_hist = vecs[i].c;
            #1;
            check("vec_ready", 32'(x_ready), 32'(vecs[i].rdy));
            @(posedge ffe_clk); #1;
            check("vec_addr", 32'(rd_addr), 32'(vecs[i].addr));
            check("vec_data", 32'(rd_data), 32'(vecs[i].data));
            check("vec_stb", 32'(str_out_n_rst_add_reg), 32'(vecs[i].stb));
            check("vec_ovld", 32'(out_valid), 32'(vecs[i].stb));
        end
        x_valid = 1'b0; clr_hist = 1'b0;

        // six samples wrap the delay line; last sequence is 6,5,4,3
        do_reset();
        for (int s = 1; s <= 6; s++) begin
            send(W'(s));
            check("wrap_tap0", 32'(got[0]), 32'(s));
        end
        for (int t = 0; t < D; t++) check("wrap_last", 32'(got[t]), 32'(6 - t));

        // reset asserted at tap 2 aborts the sequence and wipes history
        do_reset();
        x_in = W'(300); x_valid = 1'b1;
        @(posedge ffe_clk); #1;
        x_valid = 1'b0;
        repeat (2) begin @(posedge ffe_clk); #1; end
        check("abort_tap2", 32'(rd_addr), 32'd2);
        #2;
        rst = 1'b0;
        #1;
        check("abort_addr", 32'(rd_addr), 32'd0);
        check("abort_data", 32'(rd_data), 32'd0);
        check("abort_stb", 32'(str_out_n_rst_add_reg), 32'd0);
        check("abort_ovld", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(x_ready), 32'd1);
        @(negedge ffe_clk);
        rst = 1'b1;
        @(posedge ffe_clk); #1;
        send(W'(55));
        check("abort_t0", 32'(got[0]), 32'd55);
        for (int t = 1; t < D; t++) check("abort_tn", 32'(got[t]), 32'd0);

        // x_valid held high: strobe spacing and no drop/duplicate
        do_reset();
        nxt = 10; strobes = 0; last_t = 0;
        for (int cyc = 0; cyc < 41; cyc++) begin
            x_in = W'(nxt); x_valid = 1'b1; clr_hist = 1'b0;
            #1;
            acc = x_ready;
            @(posedge ffe_clk);
            if (acc) nxt++;
            #1;
            if (str_out_n_rst_add_reg) begin
                if (strobes > 0) check("held_gap", 32'(cyc - last_t), B2B ? 32'(D) : 32'(D + 1));
                check("held_data", 32'(rd_data), (strobes >= D - 1) ? 32'(10 + strobes - (D - 1)) : 32'd0);
                last_t = cyc;
                strobes++;
            end
        end
        x_valid = 1'b0;
        check("held_count", 32'(strobes), B2B ? 32'd10 : 32'd8);

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        for (int i = 0; i < 400; i++) begin
            mcycle(W'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 9) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
